// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MEM->WB pipeline boundary.
//   PIPE_DATA_W    : default data width (ALU result, read data, writeback value)
//   PIPE_DEST_W    : default register-file index width
//   mem_wb_entry_t : one MEM->WB entry at the default widths
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W = 32;
   localparam int unsigned PIPE_DEST_W = 4;

   typedef struct packed {
      logic                   wb_en;
      logic                   mem_r_en;
      logic [PIPE_DATA_W-1:0] alu_result;
      logic [PIPE_DATA_W-1:0] mem_rdata;
      logic [PIPE_DEST_W-1:0] dest;
   } mem_wb_entry_t;

endpackage

// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
// Generic valid/ready register stage with a one-entry skid so that in_ready
// is a pure flop output. FIFO order, synchronous flush, async active-high reset.
//   clk, rst            : clock, async active-high reset
//   flush               : sync clear of both entries; same-cycle accept dropped
//   in_valid/in_ready   : upstream handshake, in_ready = ~skid_valid
//   in_data [W]         : upstream payload
//   out_valid/out_ready : downstream handshake, out_valid = main entry valid
//   out_data [W]        : main entry payload
// -----------------------------------------------------------------------------
module skid_buffer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid;
   logic [W-1:0] main_data;
   logic         skid_valid;
   logic [W-1:0] skid_data;
   logic         accept;
   logic         main_free;

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;

   assign accept    = in_valid & ~skid_valid;
   // Main can take a new entry this edge if it is empty or being consumed.
   assign main_free = ~main_valid | out_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: payload flops are reset too, so held fields read as zero
         // after reset; flush only clears the valid bits.
         main_valid <= 1'b0;
         main_data  <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_free) begin
         if (skid_valid) begin
            // Oldest entry is in skid: advance it, refill skid from input.
            main_valid <= 1'b1;
            main_data  <= skid_data;
            skid_valid <= accept;
            if (accept) skid_data <= in_data;
         end else begin
            main_valid <= accept;
            if (accept) main_data <= in_data;
         end
      end else if (accept) begin
         // Main is stalled: park the new entry in skid.
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_reg
// MEM->WB pipeline register with valid/ready handshake and one-entry skid,
// synchronous flush, writeback/forwarding view and saturating stall counter.
//   clk, rst                 : clock, async active-high reset
//   flush                    : sync clear of all held entries
//   in_valid/in_ready        : MEM-side handshake (in_ready from flops only)
//   in_wb_en, in_mem_r_en    : entry writes back / entry is a load
//   in_alu_result, in_mem_rdata, in_dest : entry payload
//   out_valid/out_ready      : WB-side handshake
//   out_wb_en                : valid & wb_en & zero-dest rule
//   out_mem_r_en, out_address, out_mem_result, out_dest : held payload
//   out_wb_value             : load ? read data : ALU result
//   fwd_en/fwd_dest/fwd_value: forwarding view of the WB-stage write
//   stall_cnt                : saturating count of out_valid & ~out_ready cycles
// -----------------------------------------------------------------------------
module mem_wb_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W         = PIPE_DATA_W,
   parameter int unsigned DEST_W         = PIPE_DEST_W,
   parameter bit          ZERO_DEST_NOWB = 1'b0,
   parameter int unsigned STALL_CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_wb_en,
   input  logic                   in_mem_r_en,
   input  logic [DATA_W-1:0]      in_alu_result,
   input  logic [DATA_W-1:0]      in_mem_rdata,
   input  logic [DEST_W-1:0]      in_dest,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_wb_en,
   output logic                   out_mem_r_en,
   output logic [DATA_W-1:0]      out_address,
   output logic [DATA_W-1:0]      out_mem_result,
   output logic [DEST_W-1:0]      out_dest,
   output logic [DATA_W-1:0]      out_wb_value,
   output logic                   fwd_en,
   output logic [DEST_W-1:0]      fwd_dest,
   output logic [DATA_W-1:0]      fwd_value,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] mem_rdata;
      logic [DEST_W-1:0] dest;
   } entry_t;

   entry_t in_entry;
   entry_t held;
   logic   dest_blocked;

   assign in_entry = '{wb_en:      in_wb_en,
                       mem_r_en:   in_mem_r_en,
                       alu_result: in_alu_result,
                       mem_rdata:  in_mem_rdata,
                       dest:       in_dest};

   skid_buffer #(.W($bits(entry_t))) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (held)
   );

   // Entries are stored as given; writeback gating happens only here.
   assign dest_blocked   = ZERO_DEST_NOWB && (held.dest == '0);
   assign out_wb_en      = out_valid & held.wb_en & ~dest_blocked;
   assign out_mem_r_en   = held.mem_r_en;
   assign out_address    = held.alu_result;
   assign out_mem_result = held.mem_rdata;
   assign out_dest       = held.dest;
   assign out_wb_value   = held.mem_r_en ? held.mem_rdata : held.alu_result;

   assign fwd_en    = out_wb_en;
   assign fwd_dest  = out_dest;
   assign fwd_value = out_wb_value;

   // Flush does not touch the counter; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_skid_reg
// Directed bench. Two instances share all inputs:
//   dut   : ZERO_DEST_NOWB=0, STALL_CNT_W=16
//   dut_z : ZERO_DEST_NOWB=1, STALL_CNT_W=3
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_mem_wb_skid_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_wb_en;
   logic        in_mem_r_en;
   logic [31:0] in_alu_result;
   logic [31:0] in_mem_rdata;
   logic [3:0]  in_dest;
   logic        out_ready;

   logic        in_ready,   z_in_ready;
   logic        out_valid,  z_out_valid;
   logic        out_wb_en,  z_out_wb_en;
   logic        out_mem_r_en, z_out_mem_r_en;
   logic [31:0] out_address, z_out_address;
   logic [31:0] out_mem_result, z_out_mem_result;
   logic [3:0]  out_dest,   z_out_dest;
   logic [31:0] out_wb_value, z_out_wb_value;
   logic        fwd_en,     z_fwd_en;
   logic [3:0]  fwd_dest,   z_fwd_dest;
   logic [31:0] fwd_value,  z_fwd_value;
   logic [15:0] stall_cnt;
   logic [2:0]  z_stall_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .ZERO_DEST_NOWB(1'b0), .STALL_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
      .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_dest(in_dest),
      .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en),
      .out_mem_r_en(out_mem_r_en), .out_address(out_address),
      .out_mem_result(out_mem_result), .out_dest(out_dest), .out_wb_value(out_wb_value),
      .fwd_en(fwd_en), .fwd_dest(fwd_dest), .fwd_value(fwd_value),
      .stall_cnt(stall_cnt)
   );

   mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .ZERO_DEST_NOWB(1'b1), .STALL_CNT_W(3)) dut_z (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(z_in_ready),
      .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
      .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_dest(in_dest),
      .out_valid(z_out_valid), .out_ready(out_ready), .out_wb_en(z_out_wb_en),
      .out_mem_r_en(z_out_mem_r_en), .out_address(z_out_address),
      .out_mem_result(z_out_mem_result), .out_dest(z_out_dest), .out_wb_value(z_out_wb_value),
      .fwd_en(z_fwd_en), .fwd_dest(z_fwd_dest), .fwd_value(z_fwd_value),
      .stall_cnt(z_stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic wb, input logic r,
                        input logic [31:0] alu, input logic [31:0] rd, input logic [3:0] d);
      in_valid      = v;
      in_wb_en      = wb;
      in_mem_r_en   = r;
      in_alu_result = alu;
      in_mem_rdata  = rd;
      in_dest       = d;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 32'h1234, 32'h5678, 4'd9);

      // Reset with in_valid high
      tick();
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_fwd_en",    {31'b0, fwd_en},    32'd0);
      check("rst_out_wb_en", {31'b0, out_wb_en}, 32'd0);
      check("rst_in_ready",  {31'b0, in_ready},  32'd1);
      check("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
      check("rst_out_addr",  out_address,        32'd0);

      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      out_ready = 1'b1;
      tick();

      // ALU entry, one-cycle latency
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h55, 4'd3);
      tick();
      check("alu_out_valid", {31'b0, out_valid}, 32'd1);
      check("alu_wb_value",  out_wb_value,       32'h10);
      check("alu_fwd_en",    {31'b0, fwd_en},    32'd1);
      check("alu_fwd_dest",  {28'b0, fwd_dest},  32'd3);
      check("alu_fwd_value", fwd_value,          32'h10);

      // Load entry selects read data
      drive(1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD, 4'd5);
      tick();
      check("ld_wb_value",  out_wb_value,           32'hDEAD);
      check("ld_address",   out_address,            32'h100);
      check("ld_mem_r_en",  {31'b0, out_mem_r_en},  32'd1);
      check("ld_dest",      {28'b0, out_dest},      32'd5);
      check("ld_mem_res",   out_mem_result,         32'hDEAD);

      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      tick();
      check("drain_out_valid", {31'b0, out_valid}, 32'd0);
      check("drain_fwd_en",    {31'b0, fwd_en},    32'd0);
      check("drain_stall",     {16'b0, stall_cnt}, 32'd0);

      // Back-pressure: A, B, C back-to-back with out_ready low
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 32'hA, 32'h0, 4'd1);
      tick();
      check("bp_a_main",    out_address,         32'hA);
      check("bp_ready1",    {31'b0, in_ready},   32'd1);
      drive(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 4'd2);
      tick();
      check("bp_ready2",    {31'b0, in_ready},   32'd0);
      check("bp_a_held",    out_address,         32'hA);
      check("bp_stall1",    {16'b0, stall_cnt},  32'd1);
      drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'd3);
      tick();
      check("bp_ready3",    {31'b0, in_ready},   32'd0);
      check("bp_a_held2",   out_address,         32'hA);
      tick();
      check("bp_stall3",    {16'b0, stall_cnt},  32'd3);
      out_ready = 1'b1;
      tick();
      check("bp_b_out",     out_address,         32'hB);
      check("bp_b_valid",   {31'b0, out_valid},  32'd1);
      check("bp_ready_rel", {31'b0, in_ready},   32'd1);
      tick();
      check("bp_c_out",     out_address,         32'hC);
      check("bp_c_dest",    {28'b0, out_dest},   32'd3);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      tick();
      check("bp_empty",     {31'b0, out_valid},  32'd0);
      check("bp_stall_fin", {16'b0, stall_cnt},  32'd3);
      check("bp_stall_z",   {29'b0, z_stall_cnt}, 32'd3);

      // Flush with main and skid full and a pending input
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 32'hD, 32'h0, 4'd4);
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'hE, 32'h0, 4'd6);
      tick();
      check("fl_full_ready", {31'b0, in_ready},  32'd0);
      check("fl_full_valid", {31'b0, out_valid}, 32'd1);
      check("fl_stall_pre",  {16'b0, stall_cnt}, 32'd4);
      flush = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 32'hF, 32'h0, 4'd8);
      tick();
      flush = 1'b0;
      check("fl_out_valid",  {31'b0, out_valid}, 32'd0);
      check("fl_in_ready",   {31'b0, in_ready},  32'd1);
      check("fl_fwd_en",     {31'b0, fwd_en},    32'd0);
      check("fl_wb_en",      {31'b0, out_wb_en}, 32'd0);
      check("fl_stall_kept", {16'b0, stall_cnt}, 32'd5);
      out_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 4'd7);
      tick();
      check("fl_next_valid", {31'b0, out_valid}, 32'd1);
      check("fl_next_addr",  out_address,        32'h60);
      check("fl_next_dest",  {28'b0, out_dest},  32'd7);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      tick();
      check("fl_no_ghost",   {31'b0, out_valid}, 32'd0);

      // Zero-destination gating
      drive(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 4'd0);
      tick();
      check("z_out_valid",   {31'b0, z_out_valid}, 32'd1);
      check("z_wb_en",       {31'b0, z_out_wb_en}, 32'd0);
      check("z_fwd_en",      {31'b0, z_fwd_en},    32'd0);
      check("nz_wb_en",      {31'b0, out_wb_en},   32'd1);
      check("nz_fwd_en",     {31'b0, fwd_en},      32'd1);
      drive(1'b1, 1'b0, 1'b0, 32'h88, 32'h0, 4'd2);
      tick();
      check("nowb_valid",    {31'b0, out_valid},   32'd1);
      check("nowb_wb_en",    {31'b0, out_wb_en},   32'd0);
      check("nowb_stored",   out_address,          32'h88);
      drive(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 4'd2);
      tick();
      check("z_nonzero_wb",  {31'b0, z_out_wb_en}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      tick();

      // Stall counter saturation and asynchronous reset mid-stall
      rst = 1'b1;
      #2;
      rst = 1'b0;
      check("sat_rst_cnt",   {16'b0, stall_cnt},   32'd0);
      check("sat_rst_cnt_z", {29'b0, z_stall_cnt}, 32'd0);
      tick();
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 4'd1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      for (int i = 0; i < 10; i++) tick();
      check("sat_z_cnt",     {29'b0, z_stall_cnt}, 32'd7);
      check("sat_cnt16",     {16'b0, stall_cnt},   32'd10);
      check("sat_still_val", {31'b0, out_valid},   32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_cnt",   {16'b0, stall_cnt},   32'd0);
      check("mid_rst_cnt_z", {29'b0, z_stall_cnt}, 32'd0);
      check("mid_rst_valid", {31'b0, out_valid},   32'd0);
      check("mid_rst_ready", {31'b0, in_ready},    32'd1);
      tick();
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
Parametrised MEM→WB pipeline register with valid/ready handshake, a one-entry skid buffer, synchronous flush, and a writeback/forwarding result view. It replaces the fixed-width MEM/WB latch between data-memory access and register writeback. It lets WB back-pressure MEM without a combinational ready path, and it supplies the forwarding unit with the in-flight WB-stage write. A saturating stall counter is included for performance monitoring.

Parameters:
DATA_W, 32, width of ALU result, memory read data and writeback value
DEST_W, 4, register-file index width
ZERO_DEST_NOWB, 0, if 1 then Dest==0 never asserts writeback or forwarding
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
flush  in  1  sync clear of all held entries
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  register can accept; driven from flop state only
in_wb_en  in  1  entry writes back
in_mem_r_en  in  1  entry is a load
in_alu_result  in  DATA_W  ALU result / address
in_mem_rdata  in  DATA_W  memory read data
in_dest  in  DEST_W  destination register
out_valid  out  1  WB-stage entry valid
out_ready  in  1  WB consumes entry
out_wb_en  out  1  gated writeback enable (valid & wb_en & dest rule)
out_mem_r_en  out  1  held load flag
out_address  out  DATA_W  held ALU result
out_mem_result  out  DATA_W  held read data
out_dest  out  DEST_W  held destination
out_wb_value  out  DATA_W  out_mem_r_en ? out_mem_result : out_address
fwd_en  out  1  equals out_wb_en
fwd_dest  out  DEST_W  equals out_dest
fwd_value  out  DATA_W  equals out_wb_value
stall_cnt  out  STALL_CNT_W  cycles with out_valid & ~out_ready, saturating

Behaviour:
- Storage: main entry (drives out_*) and skid entry, each with a valid bit.
- Reset (async): both valid bits 0; all held fields 0; stall_cnt 0. Resulting outputs: out_valid 0, out_wb_en 0, fwd_en 0, in_ready 1.
- in_ready = ~skid_valid. It has no combinational dependence on out_ready.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Latency: an accepted entry reaches out_* on the next edge when main is empty or being consumed (1 cycle).
- Per edge, no flush:
  - Main empty or consumed, skid valid: skid→main. If accept, the input goes to skid; otherwise skid becomes invalid.
  - Main empty or consumed, skid empty: input→main if accept, else main becomes invalid.
  - Main held (valid & ~out_ready): if accept, the input goes to skid; main is unchanged.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Full: skid valid → in_ready 0. in_valid is ignored and the data need not be held.
- Flush (sync, highest priority): both valid bits cleared at the edge and any same-cycle accept is discarded. Data fields may keep stale values, but out_wb_en and fwd_en are 0 while invalid. in_ready is 1 the next cycle. stall_cnt is unaffected.
- Reset mid-operation: immediate clear per the reset values above, regardless of clk.
- out_wb_en = out_valid & held_wb_en & ~(ZERO_DEST_NOWB & out_dest==0).
- Gated/held fields are zeroed into storage when the entry's wb_en=0? No: they are stored as given, and gating is applied at output.
- stall_cnt increments when out_valid & ~out_ready and holds at all-ones.
- Invalid-entry forwarding: fwd_* are don't-care except fwd_en=0.

Decomposition:
- Shared package `pipe_pkg`: DATA_W/DEST_W defaults and a packed mem_wb entry struct {wb_en, mem_r_en, alu_result, mem_rdata, dest}.
- One natural sub-module: `skid_buffer`, a generic payload-width valid/ready skid with flush. mem_wb_skid_reg wraps it, adding result muxing, dest gating and the stall counter.

Test Plan:
- Reset with in_valid=1 → out_valid=0, fwd_en=0, in_ready=1, stall_cnt=0. After release, entry {wb=1, r=0, alu=0x10, dest=3} with out_ready=1 → next cycle out_wb_value=0x10, fwd_en=1, fwd_dest=3.
- Load entry {wb=1, r=1, alu=0x100, rdata=0xDEAD, dest=5} → out_wb_value=0xDEAD, out_address=0x100.
- out_ready=0; send A, B, C back-to-back → A in main, B in skid, in_ready=0 from cycle 2, C held off. Release out_ready → A, B, C consumed in order with no bubble beyond one cycle; stall_cnt equals the held cycles.
- Main and skid full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, the incoming entry is discarded, and the next accepted entry appears normally.
- ZERO_DEST_NOWB=1, entry {wb=1, dest=0} → out_valid=1, out_wb_en=0, fwd_en=0. With ZERO_DEST_NOWB=0 → out_wb_en=1.
- STALL_CNT_W=3, hold out_valid & ~out_ready for 10 cycles → stall_cnt saturates at 7. Assert rst mid-stall → stall_cnt 0 immediately.
